// File: rtl/leitor_matriz_pkg.sv
// Shared definitions for the 5x7 scanned-matrix reader.
//   estado_t   : reader FSM encoding (SYNC, CAPTURE, PUBLISH)
//   N_COLS     : number of column selects (5)
//   N_ROWS     : number of row lines (7)
//   IDX_W      : width of a column index
//   coluna_t   : one column of lit bits
//   col_index  : one-hot column select to its index
package leitor_matriz_pkg;

  localparam int N_COLS = 5;
  localparam int N_ROWS = 7;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PUBLISH = 2'd2
  } estado_t;

  typedef logic [N_ROWS-1:0] coluna_t;

  // Only meaningful for a one-hot input; for anything else it returns the
  // index of the highest set bit, which the callers never rely on.
  function automatic logic [IDX_W-1:0] col_index(input logic [N_COLS-1:0] c);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_COLS; i++) begin
      if (c[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/leitor_matriz_detector_coluna.sv
// Column-select decoder for the matrix reader.
//   c       : column selects c4..c0, active-high
//   blank   : no column selected
//   legal   : exactly one column selected
//   illegal : two or more columns selected
//   index   : index of the selected column (valid when legal)
module detector_coluna
  import leitor_matriz_pkg::*;
(
  input  logic [N_COLS-1:0] c,
  output logic              blank,
  output logic              legal,
  output logic              illegal,
  output logic [IDX_W-1:0]  index
);

  always_comb begin
    blank   = (c == '0);
    // Clearing the lowest set bit leaves zero only for a power of two.
    legal   = !blank && ((c & (c - N_COLS'(1))) == '0);
    illegal = !blank && !legal;
    index   = col_index(c);
  end

endmodule

// File: rtl/leitor_matriz.sv
// Reader for a multiplexed 5x7 LED matrix: follows the column scan, rebuilds
// a full frame in a shadow buffer, and publishes it with a valid/ready
// handshake. Also flags scan errors and detects a switched-off matrix.
//   clock_in     : system clock
//   reset_n      : asynchronous active-low reset
//   sample_en    : strobe, c and l are valid this cycle
//   c            : column selects, active-high
//   l            : row lines (polarity set by ROW_ACTIVE_LOW)
//   frame0..4    : published column data, 1 = lit
//   frame_valid  : a published frame is waiting
//   frame_ready  : consumer accepts the frame
//   overrun      : sticky, an unaccepted frame was replaced
//   scan_error   : one-cycle pulse on an illegal column sequence/pattern
//   matriz_off   : IDLE_LIMIT consecutive blank samples seen
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_SYNC    | waiting for a column-0 sample to start a frame
// ST_CAPTURE | filling shadow, k is the column currently being scanned
// ST_PUBLISH | one cycle, shadow is copied to the frame outputs
module leitor_matriz
  import leitor_matriz_pkg::*;
#(
  parameter int IDLE_LIMIT     = 16,
  parameter bit ROW_ACTIVE_LOW = 1'b1
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [N_COLS-1:0] c,
  input  logic [N_ROWS-1:0] l,
  output logic [N_ROWS-1:0] frame0,
  output logic [N_ROWS-1:0] frame1,
  output logic [N_ROWS-1:0] frame2,
  output logic [N_ROWS-1:0] frame3,
  output logic [N_ROWS-1:0] frame4,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              overrun,
  output logic              scan_error,
  output logic              matriz_off
);

  localparam logic [7:0]       LIMIT    = 8'(IDLE_LIMIT);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(N_COLS - 1);

  estado_t          state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  coluna_t          shadow_q [N_COLS];
  coluna_t          shadow_d [N_COLS];
  coluna_t          frames_q [N_COLS];
  coluna_t          pend_q, pend_d;
  logic             restart_q, restart_d;
  logic             err_d;

  logic             frame_valid_q;
  logic             overrun_q;
  logic             scan_error_q;
  logic             matriz_off_q;
  logic [7:0]       blank_cnt_q;
  logic [7:0]       blank_cnt_inc;
  logic             off_hit;

  logic             blank, legal, illegal;
  logic [IDX_W-1:0] idx;
  coluna_t          rows;

  detector_coluna u_detector (
    .c       (c),
    .blank   (blank),
    .legal   (legal),
    .illegal (illegal),
    .index   (idx)
  );

  assign rows = ROW_ACTIVE_LOW ? ~l : l;

  // Saturate at the limit so a long blank stretch never wraps back below it.
  assign blank_cnt_inc = (blank_cnt_q == LIMIT) ? blank_cnt_q : blank_cnt_q + 8'd1;
  assign off_hit       = sample_en && blank && (blank_cnt_inc == LIMIT);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    restart_d = restart_q;
    err_d     = 1'b0;

    unique case (state_q)
      ST_SYNC: begin
        if (sample_en) begin
          if (illegal) begin
            err_d = 1'b1;
          end else if (legal && (idx == '0)) begin
            state_d     = ST_CAPTURE;
            k_d         = '0;
            shadow_d[0] = rows;
          end
        end
      end

      ST_CAPTURE: begin
        if (sample_en) begin
          if (off_hit) begin
            // Matrix switched off: drop the partial frame.
            state_d = ST_SYNC;
            k_d     = '0;
            for (int i = 0; i < N_COLS; i++) shadow_d[i] = '0;
          end else if (blank) begin
            if (k_q == LAST_COL) begin
              state_d   = ST_PUBLISH;
              restart_d = 1'b0;
            end
          end else if (illegal) begin
            err_d   = 1'b1;
            state_d = ST_SYNC;
            k_d     = '0;
            for (int i = 0; i < N_COLS; i++) shadow_d[i] = '0;
          end else if (idx == k_q) begin
            shadow_d[k_q] = rows;
          end else if ((k_q != LAST_COL) && (idx == k_q + IDX_W'(1))) begin
            shadow_d[idx] = rows;
            k_d           = idx;
          end else if ((k_q == LAST_COL) && (idx == '0)) begin
            // Back-to-back frame: shadow[0] still belongs to the frame being
            // published, so the new column-0 data waits in pend until then.
            state_d   = ST_PUBLISH;
            restart_d = 1'b1;
            pend_d    = rows;
          end else begin
            err_d   = 1'b1;
            state_d = ST_SYNC;
            k_d     = '0;
            for (int i = 0; i < N_COLS; i++) shadow_d[i] = '0;
          end
        end
      end

      ST_PUBLISH: begin
        // Lasts exactly one cycle; any sample landing here only feeds the
        // blank counter, the FSM does not interpret it.
        for (int i = 0; i < N_COLS; i++) shadow_d[i] = '0;
        k_d       = '0;
        restart_d = 1'b0;
        if (restart_q && !off_hit) begin
          state_d     = ST_CAPTURE;
          shadow_d[0] = pend_q;
        end else begin
          state_d = ST_SYNC;
        end
      end

      default: begin
        state_d = ST_SYNC;
        k_d     = '0;
        for (int i = 0; i < N_COLS; i++) shadow_d[i] = '0;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_SYNC;
      k_q           <= '0;
      pend_q        <= '0;
      restart_q     <= 1'b0;
      for (int i = 0; i < N_COLS; i++) begin
        shadow_q[i] <= '0;
        frames_q[i] <= '0;
      end
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      scan_error_q  <= 1'b0;
      matriz_off_q  <= 1'b0;
      blank_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pend_q       <= pend_d;
      restart_q    <= restart_d;
      for (int i = 0; i < N_COLS; i++) shadow_q[i] <= shadow_d[i];
      scan_error_q <= err_d;

      // A publish always wins over an accept in the same cycle; overrun only
      // when the pending frame was not being taken at that moment.
      if (state_q == ST_PUBLISH) begin
        for (int i = 0; i < N_COLS; i++) frames_q[i] <= shadow_q[i];
        frame_valid_q <= 1'b1;
        if (frame_valid_q && !frame_ready) overrun_q <= 1'b1;
      end else if (frame_valid_q && frame_ready) begin
        frame_valid_q <= 1'b0;
      end

      if (sample_en) begin
        blank_cnt_q <= blank ? blank_cnt_inc : 8'd0;
        if (off_hit)     matriz_off_q <= 1'b1;
        else if (!blank) matriz_off_q <= 1'b0;
      end
    end
  end

  assign frame0      = frames_q[0];
  assign frame1      = frames_q[1];
  assign frame2      = frames_q[2];
  assign frame3      = frames_q[3];
  assign frame4      = frames_q[4];
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign scan_error  = scan_error_q;
  assign matriz_off  = matriz_off_q;

endmodule

// File: tb/tb_leitor_matriz.sv
// Directed bench for leitor_matriz with default parameters
// (IDLE_LIMIT=16, active-low rows).
module tb_leitor_matriz;
  import leitor_matriz_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_en;
  logic [4:0] c;
  logic [6:0] l;
  logic [6:0] frame0, frame1, frame2, frame3, frame4;
  logic       frame_valid;
  logic       frame_ready;
  logic       overrun;
  logic       scan_error;
  logic       matriz_off;

  int tests    = 0;
  int failures = 0;
  int err_pulses = 0;
  int err_base;

  always #5 clk = ~clk;

  always @(negedge clk) if (scan_error === 1'b1) err_pulses++;

  leitor_matriz dut (
    .clock_in    (clk),
    .reset_n     (rst_n),
    .sample_en   (sample_en),
    .c           (c),
    .l           (l),
    .frame0      (frame0),
    .frame1      (frame1),
    .frame2      (frame2),
    .frame3      (frame3),
    .frame4      (frame4),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .scan_error  (scan_error),
    .matriz_off  (matriz_off)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3, input logic [6:0] e4);
    check({tag, ".f0"}, 32'(frame0), 32'(e0));
    check({tag, ".f1"}, 32'(frame1), 32'(e1));
    check({tag, ".f2"}, 32'(frame2), 32'(e2));
    check({tag, ".f3"}, 32'(frame3), 32'(e3));
    check({tag, ".f4"}, 32'(frame4), 32'(e4));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sample cycle; returns 1 time unit after the sampling edge.
  task automatic sample(input logic [4:0] cv, input logic [6:0] lit);
    sample_en = 1'b1;
    c         = cv;
    l         = ~lit;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    c         = 5'b0;
    l         = 7'h7F;
  endtask

  // Columns 0..4, each held reps samples, with an idle cycle between samples.
  task automatic scan5(input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                       input logic [6:0] a3, input logic [6:0] a4, input int reps);
    logic [6:0] v [5];
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4;
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < reps; r++) begin
        sample(5'b00001 << i, v[i]);
        tick(1);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    sample_en   = 1'b0;
    c           = 5'b0;
    l           = 7'h7F;
    frame_ready = 1'b0;

    // Reset values while reset is held
    #3;
    check_frame("rst", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    check("rst.valid", 32'(frame_valid), 32'd0);
    check("rst.overrun", 32'(overrun), 32'd0);
    check("rst.scan_error", 32'(scan_error), 32'd0);
    check("rst.off", 32'(matriz_off), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Full scan, each column held twice, rows lit = 7'h41
    err_base = err_pulses;
    scan5(7'h41, 7'h41, 7'h41, 7'h41, 7'h41, 2);
    sample(5'b0, 7'h00);
    check("scan.publish_state", 32'(dut.state_q), 32'(ST_PUBLISH));
    check("scan.valid_before", 32'(frame_valid), 32'd0);
    tick(1);
    check("scan.valid", 32'(frame_valid), 32'd1);
    check_frame("scan", 7'h41, 7'h41, 7'h41, 7'h41, 7'h41);
    sample(5'b0, 7'h00); tick(1);
    sample(5'b0, 7'h00); tick(1);
    check("scan.no_error", 32'(err_pulses - err_base), 32'd0);
    check("scan.sync", 32'(dut.state_q), 32'(ST_SYNC));
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("scan.accepted", 32'(frame_valid), 32'd0);

    // Column skip: col0, col1, col3
    err_base = err_pulses;
    sample(5'b00001, 7'h7F); tick(1);
    sample(5'b00010, 7'h7F); tick(1);
    sample(5'b01000, 7'h7F);
    check("skip.scan_error", 32'(scan_error), 32'd1);
    check("skip.sync", 32'(dut.state_q), 32'(ST_SYNC));
    tick(1);
    check("skip.pulse_end", 32'(scan_error), 32'd0);
    check("skip.one_pulse", 32'(err_pulses - err_base), 32'd1);
    check("skip.valid", 32'(frame_valid), 32'd0);

    // Illegal pattern during capture, then recovery
    sample(5'b00001, 7'h01); tick(1);
    sample(5'b00010, 7'h02); tick(1);
    sample(5'b00110, 7'h03);
    check("illegal.scan_error", 32'(scan_error), 32'd1);
    check("illegal.sync", 32'(dut.state_q), 32'(ST_SYNC));
    tick(1);
    scan5(7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 1);
    sample(5'b0, 7'h00);
    tick(1);
    check("recover.valid", 32'(frame_valid), 32'd1);
    check_frame("recover", 7'h11, 7'h22, 7'h33, 7'h44, 7'h55);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("recover.accepted", 32'(frame_valid), 32'd0);

    // Two frames back to back, no consumer: A all lit, B all dark
    scan5(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1);
    sample(5'b00001, 7'h00);
    tick(1);
    check("frameA.valid", 32'(frame_valid), 32'd1);
    check_frame("frameA", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("frameA.overrun", 32'(overrun), 32'd0);
    check("frameB.capture", 32'(dut.state_q), 32'(ST_CAPTURE));
    for (int i = 1; i < 5; i++) begin
      sample(5'b00001 << i, 7'h00);
      tick(1);
    end
    sample(5'b0, 7'h00);
    tick(1);
    check_frame("frameB", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    check("frameB.valid", 32'(frame_valid), 32'd1);
    check("frameB.overrun", 32'(overrun), 32'd1);

    // Idle detection: clear the counter, then exactly 16 blanks
    sample(5'b00010, 7'h00); tick(1);
    for (int i = 0; i < 15; i++) begin
      sample(5'b0, 7'h00);
      tick(1);
    end
    check("idle.15", 32'(matriz_off), 32'd0);
    sample(5'b0, 7'h00);
    check("idle.16", 32'(matriz_off), 32'd1);
    check("idle.frames_kept", 32'(frame_valid), 32'd1);
    tick(1);
    sample(5'b00001, 7'h0F);
    check("wake.off", 32'(matriz_off), 32'd0);
    check("wake.capture", 32'(dut.state_q), 32'(ST_CAPTURE));
    check("wake.k", 32'(dut.k_q), 32'd0);
    tick(1);

    // Reset in the middle of a scan
    sample(5'b00010, 7'h0F); tick(1);
    sample(5'b00100, 7'h0F); tick(1);
    rst_n = 1'b0;
    #2;
    check_frame("midrst", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    check("midrst.valid", 32'(frame_valid), 32'd0);
    check("midrst.overrun", 32'(overrun), 32'd0);
    check("midrst.off", 32'(matriz_off), 32'd0);
    check("midrst.state", 32'(dut.state_q), 32'(ST_SYNC));
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("midrst.no_publish", 32'(frame_valid), 32'd0);
    scan5(7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A, 1);
    sample(5'b0, 7'h00);
    tick(1);
    check("postrst.valid", 32'(frame_valid), 32'd1);
    check_frame("postrst", 7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A);
    check("postrst.overrun", 32'(overrun), 32'd0);

    // Publish and accept in the same cycle: new frame stays, no overrun
    scan5(7'h15, 7'h16, 7'h17, 7'h18, 7'h19, 1);
    sample(5'b0, 7'h00);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("same.valid", 32'(frame_valid), 32'd1);
    check("same.overrun", 32'(overrun), 32'd0);
    check_frame("same", 7'h15, 7'h16, 7'h17, 7'h18, 7'h19);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("same.accept", 32'(frame_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/leitor_matriz.md
LEITOR_MATRIZ -- requirements
Module: leitor_matriz

Interface
REQ-001 Parameter IDLE_LIMIT, default 16, sets how many consecutive blank samples mean the matrix is off (range 2..255).
REQ-002 Parameter ROW_ACTIVE_LOW, default 1: 1 means a lit LED reads as row bit 0; 0 means it reads as row bit 1.
REQ-003 clock_in  input  1  system clock; the only clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sample_en  input  1  one-cycle strobe; c and l are stable and valid to sample.
REQ-006 c  input  5  column selects c4..c0 of the scanned 5x7 matrix, active-high.
REQ-007 l  input  7  row lines l6..l0 of the scanned matrix.
REQ-008 frame0..frame4  output  7 each  reconstructed column data; bit=1 means lit.
REQ-009 frame_valid  output  1  a completed frame is held on frame0..4.
REQ-010 frame_ready  input  1  consumer accepts the frame.
REQ-011 overrun  output  1  sticky; set when a pending frame was replaced before being accepted.
REQ-012 scan_error  output  1  one-cycle pulse on an illegal column pattern.
REQ-013 matriz_off  output  1  IDLE_LIMIT consecutive blank samples have been seen.

Function
REQ-014 All state advances only on clock_in edges where sample_en=1, except the frame_ready handshake, which is evaluated every cycle.
REQ-015 A sample is blank when c=0, legal when c is one-hot, and illegal when two or more bits of c are set.
REQ-016 The FSM has three states:
- SYNC: waits for c=00001.
- CAPTURE: holds expected column k (0..4).
- PUBLISH: one cycle; copies the shadow buffer to the outputs.
REQ-017 SYNC -> CAPTURE with k=0 on a legal c=00001 sample; that sample's rows go into shadow[0].
REQ-018 In CAPTURE, a sample with column k overwrites shadow[k]; each column may be held for any number of samples.
REQ-019 In CAPTURE, a sample with column k+1 (k<4) stores shadow[k+1] and sets k=k+1.
REQ-020 In CAPTURE, blank samples leave k and shadow unchanged.
REQ-021 In CAPTURE with k=4, a blank sample or a column-0 sample -> PUBLISH.
- A column-0 sample also writes its rows into shadow[0] and re-enters CAPTURE with k=0 after PUBLISH.
- A blank sample returns to SYNC after PUBLISH.
REQ-022 In CAPTURE, any other column, or an illegal sample: scan_error pulses one cycle, shadow is discarded, FSM -> SYNC.
REQ-023 In SYNC, an illegal sample pulses scan_error; legal non-column-0 samples are ignored.
REQ-024 Row data is stored as lit bits: ~l when ROW_ACTIVE_LOW=1, l otherwise.
REQ-025 Latency: frame0..4 and frame_valid update on the clock edge after the PUBLISH decision.
- Equivalently, 2 edges after the terminating sample_en edge.
REQ-026 frame_valid rises at PUBLISH and stays high until a cycle with frame_valid=1 and frame_ready=1, then falls on the next edge.
REQ-027 If PUBLISH occurs while frame_valid=1 and frame_ready=0:
- frames are replaced;
- overwritten data is lost;
- frame_valid stays 1;
- overrun is set.
REQ-028 If PUBLISH and an accept happen in the same cycle, the new frame wins: frame_valid stays 1 and overrun is not set.
REQ-029 overrun clears only on reset.
REQ-030 A saturating blank counter increments on each blank sample and clears on any non-blank sample.
REQ-031 When the blank counter reaches IDLE_LIMIT:
- matriz_off is set to 1;
- the FSM is forced to SYNC and shadow is discarded;
- frame outputs are kept.
REQ-032 matriz_off clears on the edge of the first non-blank sample.
REQ-033 IDLE_LIMIT takes priority over the blank-sample handling in REQ-021 only when the counter reaches the limit on that same sample.

Reset
REQ-034 While reset_n=0, all outputs and state are held at reset values:
- FSM=SYNC, k=0, shadow=0;
- frame0..4=0, frame_valid=0, overrun=0, scan_error=0, matriz_off=0;
- blank counter=0.
REQ-035 Reset assertion mid-frame aborts the capture immediately, with no PUBLISH.
REQ-036 After reset_n rises, the first sample_en is processed normally.

Structure
REQ-037 The following belong in the shared package:
- FSM state encoding (SYNC, CAPTURE, PUBLISH);
- matrix dimensions (5 columns, 7 rows);
- the one-hot column-to-index function.
REQ-038 A single sub-module, detector_coluna, is used: it decodes c into blank, legal, illegal and a 3-bit index.
REQ-039 All outputs are registered.

Verification
REQ-040 Scan columns 0..4, each held 2 samples with l=~7'h41, then 3 blanks -> frame0..4=7'h41 and frame_valid=1 two edges after the first blank; scan_error never pulses.
REQ-041 Sequence col0, col1, col3 -> scan_error one pulse at the col3 sample; FSM=SYNC; frame_valid stays 0.
REQ-042 c=5'b00110 during CAPTURE -> scan_error pulse; the next full scan 0..4 publishes correctly.
REQ-043 Two complete frames (A=all 7'h7F, then B=all 7'h00) with frame_ready=0 -> frame0..4=7'h00, frame_valid=1, overrun=1.
REQ-044 Exactly 16 blank samples -> matriz_off=1 after the 16th; one col0 sample -> matriz_off=0 and CAPTURE k=0.
REQ-045 reset_n pulsed low after col2 of a scan -> all outputs 0; a complete scan afterwards publishes normally.
